// File: rtl/tlb_walker.sv
// tlb_walker: radix page-table walker that refills the TLB on a miss.
// Define TLB_WALK_CACHE_EN to add a one-entry cache of the top-level PTE.
module tlb_walker #(
    parameter int LEVELS = 4,
    parameter int PCID_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_valid,
    output logic              miss_ready,
    input  logic [63:0]       miss_va,
    input  logic [PCID_W-1:0] miss_pcid,
    input  logic [63:0]       ptbr,
    input  logic              flush,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [63:0]       mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [63:0]       mem_rsp_data,
    output logic              fill_valid,
    output logic [63:0]       fill_va,
    output logic [63:0]       fill_pa,
    output logic [PCID_W-1:0] fill_pcid,
    output logic              fault,
    output logic [2:0]        dbg_state
);
    localparam int LVL_W   = (LEVELS > 1) ? $clog2(LEVELS) : 1;
    localparam int TOP_LSB = 12 + 9 * (LEVELS - 1);
    localparam logic [LVL_W-1:0] TOP_LVL  = LVL_W'(LEVELS - 1);
    localparam logic [LVL_W-1:0] NEXT_LVL = LVL_W'((LEVELS > 1) ? LEVELS - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_FILL  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [63:0]       va_q, base_q, pa_q;
    logic [PCID_W-1:0] pcid_q;
    logic [LVL_W-1:0]  level_q;

    logic [6:0]  shamt;
    logic [8:0]  idx;
    logic [63:0] off_mask, leaf_pa, next_base;
    logic        pte_v, pte_l, accept, rsp_take, cache_hit;
    logic [63:0] cache_base;
    logic        unused_rsp_bits;

    // Bit offset of the current level's 9-bit index; also the page-offset width of a leaf here.
    assign shamt     = 7'd12 + 7'(9 * level_q);
    assign idx       = 9'(va_q >> shamt);
    assign off_mask  = (64'd1 << shamt) - 64'd1;
    assign pte_v     = mem_rsp_data[0];
    assign pte_l     = mem_rsp_data[1];
    assign leaf_pa   = ({12'd0, mem_rsp_data[51:0]} & ~off_mask) | (va_q & off_mask);
    assign next_base = {12'd0, mem_rsp_data[51:12], 12'd0};
    assign unused_rsp_bits = ^mem_rsp_data[63:52];

    assign accept   = (state_q == S_IDLE) && miss_valid;
    assign rsp_take = (state_q == S_WAIT) && mem_rsp_valid;

    assign mem_req_addr = base_q + {52'd0, idx, 3'd0};
    assign fill_va      = va_q;
    assign fill_pa      = pa_q;
    assign fill_pcid    = pcid_q;
    assign dbg_state    = state_q;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // mem_req_valid/mem_req_addr are held unchanged until that edge.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        fill_valid    = 1'b0;
        fault         = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) state_d = S_REQ;
            end
            S_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    if (!pte_v)              state_d = S_FAULT;
                    else if (pte_l)          state_d = S_FILL;
                    else if (level_q == '0)  state_d = S_FAULT;
                    else                     state_d = S_REQ;
                end
            end
            S_FILL: begin
                fill_valid = 1'b1;
                state_d    = S_IDLE;
            end
            S_FAULT: begin
                fault   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            va_q    <= '0;
            pcid_q  <= '0;
            base_q  <= '0;
            level_q <= '0;
            pa_q    <= '0;
        end else if (accept) begin
            va_q   <= miss_va;
            pcid_q <= miss_pcid;
            if (cache_hit) begin
                level_q <= NEXT_LVL;
                base_q  <= cache_base;
            end else begin
                level_q <= TOP_LVL;
                base_q  <= ptbr;
            end
        end else if (rsp_take && pte_v) begin
            if (pte_l) begin
                pa_q <= leaf_pa;
            end else if (level_q != '0) begin
                base_q  <= next_base;
                level_q <= level_q - LVL_W'(1);
            end
        end
    end

`ifdef TLB_WALK_CACHE_EN
    logic              wc_valid;
    logic [PCID_W-1:0] wc_pcid;
    logic [8:0]        wc_tag;
    logic [63:0]       wc_ptbr, wc_base, ptbr_q;
    logic              wc_write;

    assign wc_write = rsp_take && pte_v && !pte_l && (LEVELS > 1) && (level_q == TOP_LVL);
    assign cache_hit = (LEVELS > 1) && wc_valid && (wc_pcid == miss_pcid)
                       && (wc_tag == miss_va[TOP_LSB +: 9]) && (wc_ptbr == ptbr);
    assign cache_base = wc_base;

    always_ff @(posedge clk) begin
        if (rst)         ptbr_q <= '0;
        else if (accept) ptbr_q <= ptbr;
    end

    // A flush in the same cycle as a refill leaves the entry invalid.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wc_valid <= 1'b0;
        end else if (wc_write) begin
            wc_valid <= 1'b1;
            wc_pcid  <= pcid_q;
            wc_tag   <= va_q[TOP_LSB +: 9];
            wc_ptbr  <= ptbr_q;
            wc_base  <= next_base;
        end
    end
`else
    logic unused_flush;
    assign unused_flush = flush;
    assign cache_hit    = 1'b0;
    assign cache_base   = '0;
`endif

endmodule

// File: tb/tb_tlb_walker.sv
// Directed bench for tlb_walker: in-bench page-table memory, scoreboard of expected
// fill/fault results, latency and request-address checks for both cache builds.
`timescale 1ns/1ps
module tb_tlb_walker;
    localparam int PCID_W = 12;

    logic              clk, rst, miss_valid, miss_ready, flush;
    logic              mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic              fill_valid, fault;
    logic [63:0]       miss_va, ptbr, mem_req_addr, mem_rsp_data, fill_va, fill_pa;
    logic [PCID_W-1:0] miss_pcid, fill_pcid;
    logic [2:0]        dbg_state;

    tlb_walker #(.LEVELS(4), .PCID_W(PCID_W)) dut (
        .clk(clk), .rst(rst),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_va(miss_va),
        .miss_pcid(miss_pcid), .ptbr(ptbr), .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .fill_valid(fill_valid), .fill_va(fill_va),
        .fill_pa(fill_pa), .fill_pcid(fill_pcid), .fault(fault), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          fails   = 0;
    logic [65:0] exp_q[$];      // {fault, fill, pa-or-va}
    logic [63:0] req_log[$];
    logic [63:0] mem_tbl [logic [63:0]];
    logic        hold_flush;

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pte_at(input logic [63:0] a);
        if (mem_tbl.exists(a)) return mem_tbl[a];
        return 64'h0;
    endfunction

    function automatic logic [63:0] log_at(input int i);
        if (i < req_log.size()) return req_log[i];
        return '1;
    endfunction

    task automatic flush_cache();
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Driver: issue one miss, serve memory with one-cycle response latency, observe the result.
    task automatic walk(input logic [63:0] va, input logic [PCID_W-1:0] pcid,
                        input logic [63:0] root, input int stall, output int evt_cyc);
        logic        pend, done;
        logic [63:0] pend_addr;
        logic [65:0] exp;
        int          stall_left;
        req_log.delete();
        evt_cyc = -1; pend = 1'b0; pend_addr = '0; done = 1'b0; stall_left = stall;
        check("miss_ready_idle", miss_ready, 1);
        miss_valid = 1'b1; miss_va = va; miss_pcid = pcid; ptbr = root;
        flush = hold_flush;
        @(posedge clk);
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            miss_valid = 1'($urandom_range(0, 1));
            miss_va = ~va; miss_pcid = ~pcid; ptbr = root ^ 64'h5000;
            mem_rsp_valid = pend ? 1'b1 : 1'($urandom_range(0, 1));
            mem_rsp_data  = pend ? pte_at(pend_addr) : 64'h3;
            pend = 1'b0;
            if (fill_valid || fault) begin
                done = 1'b1; evt_cyc = k;
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                check("sb_result", {fault, fill_valid, fill_valid ? fill_pa : fill_va}, exp);
                check("fill_pcid", fill_pcid, pcid);
            end else if (mem_req_valid) begin
                if (stall_left > 0) begin
                    mem_req_ready = 1'b0;
                    stall_left--;
                    check("stall_addr_stable", mem_req_addr, root);
                end else begin
                    mem_req_ready = 1'b1;
                    pend = 1'b1; pend_addr = mem_req_addr;
                    req_log.push_back(mem_req_addr);
                end
            end else begin
                mem_req_ready = 1'($urandom_range(0, 1));
            end
        end
        check("walk_done", done, 1);
        if (!done && exp_q.size() > 0) exp = exp_q.pop_front();
        @(negedge clk);
        miss_valid = 1'b0; mem_rsp_valid = 1'b0; mem_req_ready = 1'b1; flush = 1'b0;
        check("strobe_one_cycle", {fill_valid, fault}, 2'b00);
        check("ready_after_strobe", miss_ready, 1);
    endtask

    initial begin
        int          c;
        logic        found;
        logic [11:0] off;
        logic        any_evt;

        rst = 1'b1; miss_valid = 1'b0; flush = 1'b0; hold_flush = 1'b0;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        miss_va = '0; miss_pcid = '0; ptbr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_miss_ready", miss_ready, 1);
        check("rst_outputs", {mem_req_valid, fill_valid, fault}, 3'b000);
        check("rst_req_addr", mem_req_addr, 0);
        check("rst_fill_data", {fill_va, fill_pa}, 0);
        check("rst_fill_pcid", fill_pcid, 0);
        check("rst_state", dbg_state, 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // full 4-level walk
        mem_tbl[64'h1000] = 64'h2001;
        mem_tbl[64'h2000] = 64'h3001;
        mem_tbl[64'h3010] = 64'h4001;
        mem_tbl[64'h4018] = 64'h9A003;
        exp_q.push_back({2'b01, 64'h9A123});
        walk(64'h403123, 12'h5, 64'h1000, 0, c);
        check("full_latency", c, 9);
        check("full_nreq", req_log.size(), 4);
        check("full_addr0", log_at(0), 64'h1000);
        check("full_addr1", log_at(1), 64'h2000);
        check("full_addr2", log_at(2), 64'h3010);
        check("full_addr3", log_at(3), 64'h4018);

        // 2 MiB superpage at level 1
        flush_cache();
        mem_tbl[64'h3010] = 64'h600003;
        exp_q.push_back({2'b01, 64'h603123});
        walk(64'h403123, 12'h5, 64'h1000, 0, c);
        check("super_latency", c, 7);
        check("super_nreq", req_log.size(), 3);
        found = 1'b0;
        foreach (req_log[i]) if (req_log[i] == 64'h4018) found = 1'b1;
        check("super_no_l0_req", found, 0);

        // invalid PTE at level 2
        flush_cache();
        mem_tbl[64'h3010] = 64'h4001;
        mem_tbl[64'h2000] = 64'h0;
        exp_q.push_back({2'b10, 64'h403123});
        walk(64'h403123, 12'h5, 64'h1000, 0, c);
        check("fault_v0_latency", c, 5);
        check("fault_v0_nreq", req_log.size(), 2);

        // non-leaf PTE at level 0
        flush_cache();
        mem_tbl[64'h2000] = 64'h3001;
        mem_tbl[64'h4018] = 64'h5001;
        exp_q.push_back({2'b10, 64'h403123});
        walk(64'h403123, 12'h5, 64'h1000, 0, c);
        check("fault_l0_latency", c, 9);
        check("fault_l0_nreq", req_log.size(), 4);

        // request backpressure: ready low for 5 cycles on the first request
        flush_cache();
        mem_tbl[64'h4018] = 64'h9A003;
        exp_q.push_back({2'b01, 64'h9A123});
        walk(64'h403123, 12'h5, 64'h1000, 5, c);
        check("stall_latency", c, 14);
        check("stall_nreq", req_log.size(), 4);

        // second miss sharing the top-level entry
        mem_tbl[64'h4028] = 64'h7B003;
        exp_q.push_back({2'b01, 64'h7B000});
        walk(64'h405000, 12'h5, 64'h1000, 0, c);
`ifdef TLB_WALK_CACHE_EN
        check("wc_hit_addr0", log_at(0), 64'h2000);
        check("wc_hit_latency", c, 7);
`else
        check("wc_hit_addr0", log_at(0), 64'h1000);
        check("wc_hit_latency", c, 9);
`endif

        // different pcid misses the cache
        exp_q.push_back({2'b01, 64'h9A123});
        walk(64'h403123, 12'h6, 64'h1000, 0, c);
        check("wc_pcid_addr0", log_at(0), 64'h1000);
        check("wc_pcid_latency", c, 9);

        // flush empties the cache
        flush_cache();
        exp_q.push_back({2'b01, 64'h9A123});
        walk(64'h403123, 12'h6, 64'h1000, 0, c);
        check("wc_flush_addr0", log_at(0), 64'h1000);

        // flush held during a refill wins over the write
        flush_cache();
        hold_flush = 1'b1;
        exp_q.push_back({2'b01, 64'h9A123});
        walk(64'h403123, 12'h6, 64'h1000, 0, c);
        hold_flush = 1'b0;
        exp_q.push_back({2'b01, 64'h9A123});
        walk(64'h403123, 12'h6, 64'h1000, 0, c);
        check("wc_flush_win_addr0", log_at(0), 64'h1000);
        exp_q.push_back({2'b01, 64'h9A123});
        walk(64'h403123, 12'h6, 64'h1000, 0, c);
`ifdef TLB_WALK_CACHE_EN
        check("wc_refill_addr0", log_at(0), 64'h2000);
`else
        check("wc_refill_addr0", log_at(0), 64'h1000);
`endif

        // random page offsets, back-to-back
        for (int n = 0; n < 4; n++) begin
            off = 12'($urandom_range(0, 4095));
            exp_q.push_back({2'b01, 52'h9A, off});
            walk({52'h403, off}, 12'h5, 64'h1000, 0, c);
        end

        // reset during WAIT aborts the walk; a late response is dropped
        flush_cache();
        miss_valid = 1'b1; miss_va = 64'h403123; miss_pcid = 12'h5; ptbr = 64'h1000;
        mem_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        miss_valid = 1'b0;
        check("rstw_req", mem_req_valid, 1);
        @(posedge clk);
        @(negedge clk);
        check("rstw_in_wait", dbg_state, 3'd2);
        rst = 1'b1; miss_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; miss_valid = 1'b0;
        check("rstw_miss_ready", miss_ready, 1);
        check("rstw_outputs", {mem_req_valid, fill_valid, fault}, 3'b000);
        check("rstw_req_addr", mem_req_addr, 0);
        check("rstw_fill_data", {fill_va, fill_pa}, 0);
        check("rstw_fill_pcid", fill_pcid, 0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 64'h2001;
        any_evt = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            mem_rsp_valid = 1'b0;
            any_evt |= fill_valid | fault | mem_req_valid | !miss_ready;
        end
        check("rstw_late_rsp_dropped", any_evt, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/tlb_walker.md
# tlb_walker

Page-table walker that sits directly upstream of the TLB `cache` block and refills it on a miss. It accepts a miss (`va`, `pcid`) and performs a radix walk through memory over a single-outstanding read port. It then drives the translated (`va`, `pa`, `pcid`) triple into the TLB fill inputs, or raises a one-cycle fault.

## Interface
Parameters:
- `LEVELS`, 4: page-table depth; 9 VA bits per level, 4 KiB base page.
- `PCID_W`, 12: PCID width, matching the TLB.

Ports (addresses and data are 64 bits):
- `clk`  in  1  clock. One clock domain; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `miss_valid`  in  1  TLB miss request.
- `miss_ready`  out  1  walker idle; request accepted when both are high.
- `miss_va`  in  64  faulting virtual address.
- `miss_pcid`  in  PCID_W  PCID of the miss.
- `ptbr`  in  64  root table base, 4 KiB aligned; sampled at accept.
- `flush`  in  1  invalidate the walk cache (no effect when the cache is compiled out).
- `mem_req_valid`  out  1  PTE read request.
- `mem_req_ready`  in  1  memory accepts the request.
- `mem_req_addr`  out  64  PTE address.
- `mem_rsp_valid`  in  1  PTE data returned.
- `mem_rsp_data`  in  64  PTE.
- `fill_valid`  out  1  one-cycle fill strobe to the TLB.
- `fill_va`  out  64  VA for the fill or fault.
- `fill_pa`  out  64  translated PA.
- `fill_pcid`  out  PCID_W  PCID for the fill.
- `fault`  out  1  one-cycle page-fault strobe.

## Operation
- PTE format:
  - bit0 = V (valid).
  - bit1 = L (leaf).
  - bits 51:12 = PPN.
  - All other bits are ignored.
- The walker is an FSM with states IDLE, REQ, WAIT, FILL, FAULT.
- IDLE:
  - `miss_ready`=1.
  - On accept, latch `va`, `pcid` and `ptbr`; set level = LEVELS-1 and base = `ptbr`; go to REQ.
- REQ:
  - Drive `mem_req_valid`=1 with `mem_req_addr` = base + `va`[12+9*level +: 9]*8.
  - Hold the address stable until `mem_req_ready`, then go to WAIT.
- WAIT: on `mem_rsp_valid`, take the first matching rule:
  - V=0 → FAULT.
  - L=1 → FILL, with pa = {12'b0, pte[51:12+9*level], `va`[12+9*level-1:0]}. A leaf above level 0 is a superpage.
  - L=0 and level=0 → FAULT.
  - Otherwise: base = {12'b0, pte[51:12], 12'b0}, level = level-1, go to REQ.
- FILL: `fill_valid`=1 for exactly one cycle, then IDLE. The TLB has no backpressure.
- FAULT: `fault`=1 for exactly one cycle, with `fill_va`/`fill_pcid` valid and `fill_valid`=0; then IDLE.
- Walker is non-pipelined: one walk in flight, one memory request in flight.
- `mem_rsp_valid` outside WAIT is ignored.
- `miss_va`, `miss_pcid` and `ptbr` changing mid-walk have no effect.

## Timing
- Reset values:
  - State = IDLE.
  - `miss_ready`=1.
  - `mem_req_valid`=0, `fill_valid`=0, `fault`=0.
  - `mem_req_addr`, `fill_va`, `fill_pa`, `fill_pcid` = 0.
  - Walk cache invalid.
- `rst` wins over every other input in the same cycle. Reset mid-walk aborts it: no fill or fault is produced, and a late response is dropped in IDLE.
- Latency with memory that is always ready and responds in the cycle after the request:
  - Accept at cycle 0.
  - Level-n request in REQ, response in WAIT: 2 cycles per level.
  - Full 4-level walk: `fill_valid` at cycle 9.
  - Each cache-skipped level saves 2 cycles.
- `miss_ready` deasserts in the cycle after accept and reasserts in the cycle after FILL or FAULT.
- Back-to-back misses:
  - A new miss can be accepted in the first IDLE cycle after the strobe.
  - The minimum gap between accepts is walk latency + 1.

## Configuration
- `TLB_WALK_CACHE_EN` defined:
  - Adds a one-entry cache of {pcid, `va`[12+9*(LEVELS-1) +: 9], `ptbr`, next-level base}.
  - Written when a non-leaf top-level PTE returns.
  - On accept with all three tags matching, the walk starts at level LEVELS-2 from the cached base, skipping one memory read.
  - `flush` or `rst` clears the entry. A `flush` in the same cycle as a write wins.
- `TLB_WALK_CACHE_EN` undefined:
  - Every walk starts at the root.
  - `flush` is ignored.
  - Output timing is identical to the cached build with the cache always missing.

## Test plan
- Full walk, common setup: `ptbr`=0x1000, va=0x403123, pcid=0x5. PTEs returned 0x2001 @0x1000 → 0x3001 @0x2000 → 0x4001 @0x3010 → 0x9A003 @0x4018 → `fill_valid` at cycle 9 with pa=0x9A123, pcid=0x5, and exactly 4 requests issued.
- Superpage: same setup, but respond 0x600003 @0x3010 → fill pa=0x603123 after 3 requests, with no request to 0x4018.
- Fault: respond 0x0 @0x2000 → `fault`=1 for one cycle with `fill_va`=0x403123, `fill_valid` never asserted, `miss_ready`=1 the following cycle. Separately, a non-leaf PTE at level 0 → fault.
- Backpressure and reset:
  - Hold `mem_req_ready`=0 for 5 cycles → `mem_req_addr` stays stable at 0x1000.
  - Assert `rst` during WAIT → all outputs return to reset values next cycle, and a subsequent `mem_rsp_valid` produces no fill.
- Walk cache (`TLB_WALK_CACHE_EN`):
  - Second miss va=0x405000, same pcid and `ptbr` → first request address is 0x2000 and fill arrives at cycle 7.
  - Repeat with pcid=0x6, or after `flush` → first address is 0x1000.
